// File: rtl/dpram_wr_ctrl.sv
// ============================================================================
// Module   : dpram_wr_ctrl
// Brief    : Write-side sequencer for a simple dual-port RAM. Packs DEPTH
//            stream bytes into the RAM as one frame and raises frame_rdy. It
//            then holds the producer off until rd_release returns the buffer.
//            It also offers a clear sequence that zeroes every RAM entry.
//            Optional feature macro: DPRAM_WR_OVF_EN (rejected-beat counter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_wr_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              clr_req,
  input  logic              rd_release,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              frame_rdy,
  output logic              busy,
  output logic [7:0]        ovf_cnt
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;

  // Ready only while filling; a pending clear wins over the beat, and reset
  // keeps the producer stalled.
  assign s_ready = rst_n && (r_state == ST_FILL) && !clr_req;

  // Main sequencer: frame fill, hand-off hold and RAM clear.
  // The clear issues address 0 on its entry edge so that busy and the write
  // strobe both span exactly DEPTH cycles; r_wr_ptr then names the next clear
  // address and has wrapped back to 0 once the final entry has been issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FILL;
      r_wr_ptr  <= '0;
      ram_w_en  <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      frame_rdy <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (clr_req) begin
            r_state  <= ST_CLEAR;
            busy     <= 1'b1;
            ram_w_en <= 1'b1;
            ram_addr <= '0;
            ram_data <= '0;
            r_wr_ptr <= ADDR_W'(1);
          end else if (s_valid) begin
            ram_w_en <= 1'b1;
            ram_addr <= r_wr_ptr;
            ram_data <= s_data;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == C_LAST_ADDR) begin
              r_state <= ST_HOLD;
            end
          end else begin
            ram_w_en <= 1'b0;
          end
        end

        ST_HOLD: begin
          ram_w_en <= 1'b0;
          if (rd_release) begin
            frame_rdy <= 1'b0;
            r_state   <= ST_FILL;
          end else begin
            frame_rdy <= 1'b1;
          end
        end

        ST_CLEAR: begin
          if (r_wr_ptr == '0) begin
            busy     <= 1'b0;
            ram_w_en <= 1'b0;
            r_state  <= ST_FILL;
          end else begin
            ram_w_en <= 1'b1;
            ram_addr <= r_wr_ptr;
            ram_data <= '0;
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end

        default: begin
          r_state  <= ST_FILL;
          r_wr_ptr <= '0;
          ram_w_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DPRAM_WR_OVF_EN
  logic [7:0] r_ovf_cnt;

  // Count beats offered while the frame is held; saturating, zeroed by a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_cnt <= 8'h00;
    end else if ((r_state == ST_FILL) && clr_req) begin
      r_ovf_cnt <= 8'h00;
    end else if ((r_state == ST_HOLD) && s_valid && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'h01;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  assign ovf_cnt = 8'h00;
`endif

endmodule

`default_nettype wire
